om_write_scheduler: RTL and testbench
=====================================

// Module: om_write_scheduler
// PURPOSE
//  Shares the single Output Memory write port (OMWE/OMWAR/OMWDR) among NREQ
//  requesters, e.g. parallel relaxation lanes of the Bellman-Ford engine.
//  Each requester has a 2-deep FIFO. The FIFOs are drained round-robin, one
//  write per cycle.
//  Built-in clear sweep fills every address with CLEAR_VAL (16'hFFFF = infinity)
//  before a run. idle tells the top level when it is safe to raise Finish.
// PARAMETERS
//  NREQ       4        number of write requesters (2..8)
//  AW         13       address width (Output Memory depth 2**AW = 8192)
//  DW         16       data width
//  CLEAR_VAL  16'hFFFF value written by the clear sweep
// PORTS
//  clock        in   1        rising-edge clock
//  reset        in   1        asynchronous, active-low reset
//  clear_start  in   1        one-cycle pulse: begin clear sweep
//  clear_busy   out  1        high while sweep in progress
//  req_valid    in   NREQ     per-requester write request
//  req_ready    out  NREQ     per-requester FIFO not full
//  req_addr     in   NREQ*AW  packed addresses, lane i at [i*AW +: AW]
//  req_data     in   NREQ*DW  packed data, lane i at [i*DW +: DW]
//  OMWE         out  1        Output Memory write enable (registered)
//  OMWAR        out  AW       Output Memory write address (registered)
//  OMWDR        out  DW       Output Memory write data (registered)
//  idle         out  1        RUN state, all FIFOs empty, OMWE low
// BEHAVIOUR
//  Reset (reset=0, async): FIFOs emptied; RR pointer=0; sweep counter=0;
//   state=RUN. OMWE=0, OMWAR=0, OMWDR=0, clear_busy=0; req_ready=all 1s, idle=1.
//  Handshake: lane i entry pushed on the edge where req_valid[i]&&req_ready[i].
//   - req_ready[i]=!full[i], combinational from FIFO state only.
//   - A simultaneous push and pop on a full FIFO is not accepted (no bypass).
//  Latency: push at edge t -> earliest OMWE=1 for that entry in cycle t+1.
//   The SRAM write commits at edge t+2.
//  FSM states RUN, CLEAR.
//   - RUN -> CLEAR: clear_start=1.
//   - CLEAR -> RUN: after the cycle that drives address 2**AW-1.
//   - clear_start while in CLEAR is ignored.
//  RUN: among non-empty FIFOs, grant the first lane at or after the RR pointer.
//   - Pop that lane; register its addr/data to OMWAR/OMWDR; OMWE=1.
//   - RR pointer <= grant+1 mod NREQ.
//   - No non-empty FIFO: OMWE=0, pointer holds, OMWAR/OMWDR hold.
//  CLEAR: OMWE=1 every cycle; OMWAR=cnt; OMWDR=CLEAR_VAL; cnt 0..2**AW-1.
//   - cnt wraps to 0 on exit.
//   - FIFOs keep accepting until full but are not drained.
//   - clear_busy=1 from the cycle after clear_start until the last sweep write.
//  Same address, two lanes: written in grant order; later grant wins. No merging.
//  Per-lane order is preserved (FIFO).
//  Reset asserted mid-sweep or mid-drain: pending entries discarded; state=RUN.
// CONFIGURATION
//  OMWS_PRIO0_EN defined: lane 0 has strict priority over the RR group.
//   - Lanes 1..NREQ-1 rotate among themselves and are served only when lane 0
//     is empty.
//   - RR pointer ranges 1..NREQ-1; reset value 1.
//  Not defined: pure round-robin over all NREQ lanes, as above.
// STRUCTURE
//  Shared package om_pkg: AW/DW defaults, CLEAR_VAL, RUN/CLEAR state encodings.
//  Sub-module om_req_fifo: 2-entry FIFO of {addr,data}.
//   - Ports: push, pop, full, empty, head.
//   - Instantiated NREQ times via generate.
//  Top level holds the FSM, sweep counter, RR arbiter and output registers.
// TESTING
//  1 Reset then clear_start=1 for 1 cycle -> 8192 consecutive OMWE cycles.
//     Addresses 0..8191 with data FFFF; then clear_busy=0 and idle=1.
//  2 Lanes 0..3 each push 1 entry in the same cycle (addr 10+i, data i)
//     -> writes at addr 10,11,12,13 on 4 consecutive cycles; pointer ends at 0.
//  3 Lane 2 pushes 3 times back-to-back while lanes 0,1,3 are busy
//     -> req_ready[2]=0 after 2 accepted pushes; third push is held until a
//     pop frees a slot.
//  4 Lanes 1 and 3 both write addr 5 (data AAAA, BBBB), pointer=2
//     -> lane 3 is written first, lane 1 second; final mem[5]=AAAA.
//  5 Assert reset during the sweep at cnt=100 with 2 entries queued
//     -> OMWE=0 immediately; no further writes; idle=1 after release.
//  6 OMWS_PRIO0_EN defined, lanes 0 and 2 continuously valid
//     -> every grant goes to lane 0 until it stops; then lane 2 is served.

Source files
------------

// File: rtl/om_pkg.sv
// Shared definitions for the Output Memory write scheduler.
//   OM_AW / OM_DW : default address / data widths of the Output Memory port
//   OM_CLEAR_VAL  : value written by the clear sweep (all ones = infinity)
//   om_state_e    : scheduler FSM state encodings (RUN, CLEAR)
package om_pkg;

    localparam int          OM_AW        = 13;
    localparam int          OM_DW        = 16;
    localparam logic [15:0] OM_CLEAR_VAL = 16'hFFFF;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_CLEAR = 1'b1
    } om_state_e;

endpackage

// File: rtl/om_req_fifo.sv
// Two-entry FIFO holding one requester's pending {addr,data} writes.
// Ports:
//   clock, reset : rising-edge clock, asynchronous active-low reset
//   push, wdata  : enqueue wdata (ignored when full)
//   pop          : dequeue head (ignored when empty)
//   full, empty  : occupancy flags, straight from registered state
//   head         : oldest entry, valid when !empty
module om_req_fifo #(
    parameter int W = 29
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    logic [W-1:0] mem_q [2];
    logic         wp_q, wp_d;
    logic         rp_q, rp_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         push_ok, pop_ok;

    assign full    = (cnt_q == 2'd2);
    assign empty   = (cnt_q == 2'd0);
    assign head    = mem_q[rp_q];
    // Push is refused on a full FIFO even if a pop happens the same cycle.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        wp_d  = wp_q;
        rp_d  = rp_q;
        cnt_d = cnt_q;
        if (push_ok) wp_d = ~wp_q;
        if (pop_ok)  rp_d = ~rp_q;
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wp_q  <= 1'b0;
            rp_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    // Payload storage carries no reset; the pointers say what is valid.
    always_ff @(posedge clock) begin
        if (push_ok) mem_q[wp_q] <= wdata;
    end

endmodule

// File: rtl/om_write_scheduler.sv
// Output Memory write-port scheduler.
// Shares the single OMWE/OMWAR/OMWDR write port among NREQ requesters, each
// buffered by a 2-entry FIFO and drained round-robin at one write per cycle.
// A clear sweep (clear_start pulse) writes CLEAR_VAL to every address.
// Ports:
//   clock, reset         : rising-edge clock, asynchronous active-low reset
//   clear_start          : pulse, start clear sweep (ignored while sweeping)
//   clear_busy           : sweep in progress
//   req_valid/req_ready  : per-lane handshake, ready = FIFO not full
//   req_addr/req_data    : packed per-lane address/data, lane i at [i*W +: W]
//   OMWE/OMWAR/OMWDR     : registered Output Memory write port
//   idle                 : RUN state, all FIFOs empty, OMWE low
// Configuration macro OMWS_PRIO0_EN: lane 0 gets strict priority and lanes
// 1..NREQ-1 rotate among themselves. Undefined: plain round-robin over all.
module om_write_scheduler
    import om_pkg::*;
#(
    parameter int            NREQ      = 4,
    parameter int            AW        = OM_AW,
    parameter int            DW        = OM_DW,
    parameter logic [DW-1:0] CLEAR_VAL = DW'(OM_CLEAR_VAL)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               clear_start,
    output logic               clear_busy,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic               OMWE,
    output logic [AW-1:0]      OMWAR,
    output logic [DW-1:0]      OMWDR,
    output logic               idle
);

    localparam int PW = $clog2(NREQ);

`ifdef OMWS_PRIO0_EN
    localparam int            RR_LO  = 1;
    localparam logic [PW-1:0] RR_RST = PW'(1);
`else
    localparam int            RR_LO  = 0;
    localparam logic [PW-1:0] RR_RST = '0;
`endif

    om_state_e       state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   rr_q, rr_d;
    logic            omwe_q, omwe_d;
    logic [AW-1:0]   omwar_q, omwar_d;
    logic [DW-1:0]   omwdr_q, omwdr_d;

    logic [NREQ-1:0] push, pop, full, empty;
    logic [AW-1:0]   head_addr [NREQ];
    logic [DW-1:0]   head_data [NREQ];
    logic            gnt_vld;
    logic [PW-1:0]   gnt_idx;

    // Lane k positions after base, wrapping back into the range lo..NREQ-1.
    function automatic logic [PW-1:0] wrap_lane(input int base, input int k, input int lo);
        int idx;
        idx = base + k;
        if (idx >= NREQ) idx = idx - NREQ + lo;
        return PW'(idx);
    endfunction

    assign req_ready = ~full;
    assign push      = req_valid & ~full;

    for (genvar i = 0; i < NREQ; i++) begin : g_fifo
        logic [AW+DW-1:0] head;
        om_req_fifo #(.W(AW + DW)) u_fifo (
            .clock (clock),
            .reset (reset),
            .push  (push[i]),
            .wdata ({req_addr[i*AW +: AW], req_data[i*DW +: DW]}),
            .pop   (pop[i]),
            .full  (full[i]),
            .empty (empty[i]),
            .head  (head)
        );
        assign head_addr[i] = head[AW+DW-1 -: AW];
        assign head_data[i] = head[DW-1:0];
    end

    // Grant: first non-empty lane at or after the RR pointer.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
`ifdef OMWS_PRIO0_EN
        if (!empty[0]) begin
            gnt_vld = 1'b1;
        end else begin
            for (int k = 0; k < NREQ - 1; k++) begin
                if (!gnt_vld && !empty[wrap_lane(int'(rr_q), k, RR_LO)]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = wrap_lane(int'(rr_q), k, RR_LO);
                end
            end
        end
`else
        for (int k = 0; k < NREQ; k++) begin
            if (!gnt_vld && !empty[wrap_lane(int'(rr_q), k, RR_LO)]) begin
                gnt_vld = 1'b1;
                gnt_idx = wrap_lane(int'(rr_q), k, RR_LO);
            end
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rr_d    = rr_q;
        omwe_d  = 1'b0;
        omwar_d = omwar_q;
        omwdr_d = omwdr_q;
        pop     = '0;
        case (state_q)
            ST_RUN: begin
                if (gnt_vld) begin
                    pop[gnt_idx] = 1'b1;
                    omwe_d       = 1'b1;
                    omwar_d      = head_addr[gnt_idx];
                    omwdr_d      = head_data[gnt_idx];
`ifdef OMWS_PRIO0_EN
                    // Lane 0 sits outside the rotation and leaves the pointer alone.
                    if (gnt_idx != '0) rr_d = wrap_lane(int'(gnt_idx), 1, RR_LO);
`else
                    rr_d = wrap_lane(int'(gnt_idx), 1, RR_LO);
`endif
                end
                if (clear_start) state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                // FIFOs keep filling but are not drained during the sweep.
                omwe_d  = 1'b1;
                omwar_d = cnt_q;
                omwdr_d = CLEAR_VAL;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == '1) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            rr_q    <= RR_RST;
            omwe_q  <= 1'b0;
            omwar_q <= '0;
            omwdr_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
            omwe_q  <= omwe_d;
            omwar_q <= omwar_d;
            omwdr_q <= omwdr_d;
        end
    end

    assign OMWE       = omwe_q;
    assign OMWAR      = omwar_q;
    assign OMWDR      = omwdr_q;
    assign clear_busy = (state_q == ST_CLEAR);
    assign idle       = (state_q == ST_RUN) && (&empty) && !omwe_q;

endmodule

// File: tb/tb_om_write_scheduler.sv
module tb_om_write_scheduler;

    localparam int NREQ = 4;
    localparam int AW   = 13;
    localparam int DW   = 16;

    logic               clock = 1'b0;
    logic               reset = 1'b0;
    logic               clear_start = 1'b0;
    logic               clear_busy;
    logic [NREQ-1:0]    req_valid = '0;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*AW-1:0] req_addr = '0;
    logic [NREQ*DW-1:0] req_data = '0;
    logic               OMWE;
    logic [AW-1:0]      OMWAR;
    logic [DW-1:0]      OMWDR;
    logic               idle;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0]    mem [2**AW];
    logic [AW+DW-1:0] wq [$];

    om_write_scheduler #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clock       (clock),
        .reset       (reset),
        .clear_start (clear_start),
        .clear_busy  (clear_busy),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .OMWE        (OMWE),
        .OMWAR       (OMWAR),
        .OMWDR       (OMWDR),
        .idle        (idle)
    );

    always #5 clock = ~clock;

    // SRAM model: a write driven during a cycle commits at the next rising edge.
    always @(posedge clock) begin
        if (OMWE === 1'b1) begin
            wq.push_back({OMWAR, OMWDR});
            mem[OMWAR] <= OMWDR;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int lane, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[lane]           = 1'b1;
        req_addr[lane*AW +: AW]   = a;
        req_data[lane*DW +: DW]   = d;
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while (idle !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 32'(idle), 32'd1);
    endtask

    task automatic chk_wr(input string tag, input int idx, input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (idx < wq.size()) chk(tag, 32'(wq[idx]), 32'({a, d}));
        else                 chk(tag, 32'(wq.size()), 32'(idx + 1));
    endtask

    initial begin
        int n;
        int bad;

        // Reset state
        #1;
        chk("rst_omwe",  32'(OMWE), 32'd0);
        chk("rst_omwar", 32'(OMWAR), 32'd0);
        chk("rst_omwdr", 32'(OMWDR), 32'd0);
        chk("rst_busy",  32'(clear_busy), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'hF);
        chk("rst_idle",  32'(idle), 32'd1);
        tick();
        tick();
        reset = 1'b1;
        tick();

        // 1: full clear sweep
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        chk("t1_busy_on", 32'(clear_busy), 32'd1);
        chk("t1_omwe_lat", 32'(OMWE), 32'd0);
        tick();
        n   = 0;
        bad = 0;
        while (OMWE === 1'b1 && n < 9000) begin
            if (OMWAR !== AW'(n) || OMWDR !== 16'hFFFF) bad++;
            n++;
            tick();
        end
        chk("t1_count", 32'(n), 32'd8192);
        chk("t1_bad", 32'(bad), 32'd0);
        chk("t1_busy_off", 32'(clear_busy), 32'd0);
        chk("t1_idle", 32'(idle), 32'd1);
        chk("t1_mem_last", 32'(mem[8191]), 32'hFFFF);
        wq.delete();

`ifndef OMWS_PRIO0_EN
        // 2: all four lanes push at once, written in lane order
        for (int i = 0; i < NREQ; i++) drive(i, AW'(10 + i), DW'(i));
        tick();
        req_valid = '0;
        chk("t2_lat0", 32'(OMWE), 32'd0);
        tick();
        chk("t2_lat1_we", 32'(OMWE), 32'd1);
        chk("t2_lat1_addr", 32'(OMWAR), 32'd10);
        drain("t2_drain", 20);
        chk("t2_n", 32'(wq.size()), 32'd4);
        for (int i = 0; i < NREQ; i++) chk_wr("t2_wr", i, AW'(10 + i), DW'(i));

        // 2b: pointer back at 0 -> lane 0 beats lane 3
        wq.delete();
        drive(3, 13'd23, 16'h0023);
        drive(0, 13'd20, 16'h0020);
        tick();
        req_valid = '0;
        drain("t2b_drain", 20);
        chk("t2b_n", 32'(wq.size()), 32'd2);
        chk_wr("t2b_wr0", 0, 13'd20, 16'h0020);
        chk_wr("t2b_wr1", 1, 13'd23, 16'h0023);

        // 3: lane 2 pushes three times while the other lanes are loaded
        wq.delete();
        for (int i = 0; i < NREQ; i++) drive(i, AW'(100 + i*8 + 1), DW'(i*16 + 1));
        tick();
        for (int i = 0; i < NREQ; i++) drive(i, AW'(100 + i*8 + 2), DW'(i*16 + 2));
        tick();
        req_valid = '0;
        chk("t3_ready_full", 32'(req_ready), 32'h1);
        drive(2, 13'd119, 16'h0023);
        tick();
        chk("t3_held_c", 32'(req_ready[2]), 32'd0);
        tick();
        chk("t3_free_d", 32'(req_ready[2]), 32'd1);
        tick();
        req_valid = '0;
        drain("t3_drain", 40);
        chk("t3_n", 32'(wq.size()), 32'd9);
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < NREQ; i++)
                chk_wr("t3_wr", k*4 + i, AW'(100 + i*8 + k + 1), DW'(i*16 + k + 1));
        chk_wr("t3_wr_last", 8, 13'd119, 16'h0023);

        // 4: pointer set to 2, lanes 1 and 3 hit the same address
        wq.delete();
        drive(1, 13'd30, 16'h0030);
        tick();
        req_valid = '0;
        drain("t4_setup", 20);
        drive(1, 13'd5, 16'hAAAA);
        drive(3, 13'd5, 16'hBBBB);
        tick();
        req_valid = '0;
        drain("t4_drain", 20);
        chk("t4_n", 32'(wq.size()), 32'd3);
        chk_wr("t4_wr_first", 1, 13'd5, 16'hBBBB);
        chk_wr("t4_wr_second", 2, 13'd5, 16'hAAAA);
        tick();
        chk("t4_mem5", 32'(mem[5]), 32'hAAAA);
`else
        // 6: lane 0 strict priority over lane 2
        wq.delete();
        for (int k = 0; k < 6; k++) begin
            drive(0, AW'(200 + k), DW'(16'h0100 + k));
            drive(2, AW'(300 + k), DW'(16'h0300 + k));
            tick();
        end
        req_valid = '0;
        drain("t6_drain", 40);
        chk("t6_n", 32'(wq.size()), 32'd8);
        for (int k = 0; k < 6; k++) chk_wr("t6_lane0", k, AW'(200 + k), DW'(16'h0100 + k));
        chk_wr("t6_lane2a", 6, 13'd300, 16'h0300);
        chk_wr("t6_lane2b", 7, 13'd301, 16'h0301);
`endif

        // 5: reset during the sweep with two entries queued
        wq.delete();
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        drive(0, 13'd77, 16'h7777);
        drive(1, 13'd78, 16'h7878);
        tick();
        req_valid = '0;
        chk("t5_queued", 32'(req_ready), 32'hF);
        n = 0;
        while (!(OMWE === 1'b1 && OMWAR === 13'd100) && n < 300) begin
            tick();
            n++;
        end
        chk("t5_reach100", 32'(OMWAR), 32'd100);
        reset = 1'b0;
        #1;
        chk("t5_omwe_async", 32'(OMWE), 32'd0);
        chk("t5_busy_async", 32'(clear_busy), 32'd0);
        tick();
        reset = 1'b1;
        for (int k = 0; k < 10; k++) tick();
        chk("t5_no_writes", 32'(wq.size()), 32'd100);
        chk("t5_idle", 32'(idle), 32'd1);
        chk("t5_omwe", 32'(OMWE), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
